// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter: fixed or rotating priority, single or demand
// transfer mode, and the HRQ/HLDA bus handshake with the CPU.
module dma_priority_arbiter #(
  parameter int unsigned DEMAND_MAX = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic       controllerDisable,
  input  logic       priorityType,
  input  logic [3:0] demandMode,
  input  logic       HLDA,
  input  logic       transferDone,
  input  logic       EOP_N,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic       grantValid,
  output logic [1:0] grantChannel,
  output logic [7:0] priorityOrder
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_HOLD    = 4'b0010,
    S_GRANT   = 4'b0100,
    S_RELEASE = 4'b1000
  } state_e;

  localparam logic [7:0] ORDER_RST = 8'b11_10_01_00;
  localparam logic [8:0] DMAX      = 9'(DEMAND_MAX);

  state_e     state_q, state_d;
  logic [1:0] gnt_ch_q, gnt_ch_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] order_q, order_d;

  logic [3:0] eff_req;
  logic       win_found;
  logic [1:0] win_ch;
  logic [1:0] pos;
  logic [7:0] rot;
  logic [8:0] cnt_inc;
  logic       release_now;

  assign eff_req = DREQ & ~maskReg;
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // Scan from lowest slot downward so the highest-priority requester is left last.
  always_comb begin
    win_found = 1'b0;
    win_ch    = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (eff_req[order_q[2*i +: 2]]) begin
        win_found = 1'b1;
        win_ch    = order_q[2*i +: 2];
      end
    end
  end

  // Serviced channel drops to the lowest slot; those behind it move up one.
  always_comb begin
    pos = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (order_q[2*i +: 2] == gnt_ch_q) pos = 2'(i);
    end
    rot = order_q;
    for (int i = 0; i < 3; i++) begin
      if (i >= int'(pos)) rot[2*i +: 2] = order_q[2*(i+1) +: 2];
    end
    rot[7:6] = gnt_ch_q;
  end

  always_comb begin
    state_d     = state_q;
    gnt_ch_d    = gnt_ch_q;
    cnt_d       = cnt_q;
    order_d     = priorityType ? order_q : ORDER_RST;
    release_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found && !controllerDisable && !HLDA) begin
          gnt_ch_d = win_ch;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!eff_req[gnt_ch_q]) begin
          state_d = S_IDLE;
        end else if (HLDA) begin
          state_d = S_GRANT;
          cnt_d   = 8'd0;
        end
      end
      S_GRANT: begin
        if (!EOP_N || !HLDA) begin
          release_now = 1'b1;
        end else if (transferDone) begin
          cnt_d = cnt_inc[7:0];
          if (!(demandMode[gnt_ch_q] && eff_req[gnt_ch_q] && (cnt_inc < DMAX)))
            release_now = 1'b1;
        end
        if (release_now) begin
          state_d = S_RELEASE;
          if (priorityType) order_d = rot;
        end
      end
      S_RELEASE: begin
        if (!HLDA) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      gnt_ch_q <= 2'b00;
      cnt_q    <= 8'd0;
      order_q  <= ORDER_RST;
    end else begin
      state_q  <= state_d;
      gnt_ch_q <= gnt_ch_d;
      cnt_q    <= cnt_d;
      order_q  <= order_d;
    end
  end

  assign HRQ           = (state_q == S_HOLD) || (state_q == S_GRANT);
  assign grantValid    = (state_q == S_GRANT);
  assign DACK          = grantValid ? (4'b0001 << gnt_ch_q) : 4'b0000;
  assign grantChannel  = gnt_ch_q;
  assign priorityOrder = order_q;

endmodule
